seg7_display_ctrl: RTL and testbench

Display scheduler that shares the 8-digit seven-segment display driver between four 32-bit requesters (e.g. PC, instruction, register probe, memory probe). It selects one valid source at a time, either auto-rotating on a dwell timer or stepping on a manual `next` pulse. It skips sources that are not valid and drives the driver's `i_number`/`ena` pair. It sits between the CPU debug taps and the seven-segment driver on the board top level.

---
 rtl/seg7_display_ctrl.sv | 131 +++++++++++++
 tb/tb_seg7_display_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl: shares one 8-digit seven-segment driver between four 32-bit debug sources.
// Ports: clk/rst (async, active-high); src_data/src_valid (four sources, 32 bits each); mode_auto/next/freeze (control);
//        o_number/o_ena (to the display driver), o_src (selected index), o_none (no valid source, display shows 0).
module seg7_display_ctrl #(
    parameter int DWELL = 50_000_000,
    parameter int CNT_W = 26
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] src_data,
    input  logic [3:0]   src_valid,
    input  logic         mode_auto,
    input  logic         next,
    input  logic         freeze,
    output logic [31:0]  o_number,
    output logic         o_ena,
    output logic [1:0]   o_src,
    output logic         o_none
);

    typedef enum logic [1:0] {IDLE, SCAN, SHOW} state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    state_t             state, state_nx;
    logic [1:0]         cur, cur_nx;
    logic [1:0]         cand, cand_nx;
    logic [2:0]         miss, miss_nx;
    logic [CNT_W-1:0]   dwell, dwell_nx;
    logic [31:0]        number_nx;
    logic               ena_nx;
    logic               none_nx;
    logic               advance;
    logic [3:0][31:0]   src_word;

    assign src_word = src_data;
    assign o_src    = cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cur      <= 2'd0;
            cand     <= 2'd0;
            miss     <= 3'd0;
            dwell    <= '0;
            o_number <= 32'd0;
            o_ena    <= 1'b0;
            o_none   <= 1'b1;
        end else begin
            state    <= state_nx;
            cur      <= cur_nx;
            cand     <= cand_nx;
            miss     <= miss_nx;
            dwell    <= dwell_nx;
            o_number <= number_nx;
            o_ena    <= ena_nx;
            o_none   <= none_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cur_nx    = cur;
        cand_nx   = cand;
        miss_nx   = miss;
        dwell_nx  = dwell;
        number_nx = o_number;
        ena_nx    = o_ena;
        none_nx   = o_none;
        advance   = 1'b0;

        case (state)
            IDLE: begin
                number_nx = 32'd0;
                ena_nx    = 1'b1;
                none_nx   = 1'b1;
                // Start from the current index so a returning source keeps its slot.
                if (|src_valid) begin
                    state_nx = SCAN;
                    cand_nx  = cur;
                    miss_nx  = 3'd0;
                end
            end

            SCAN: begin
                if (src_valid[cand]) begin
                    cur_nx   = cand;
                    dwell_nx = '0;
                    state_nx = SHOW;
                end else begin
                    cand_nx = cand + 2'd1;
                    miss_nx = miss + 3'd1;
                    // Fourth consecutive miss: every source has been checked once.
                    if (miss == 3'd3) begin
                        state_nx = IDLE;
                    end
                end
            end

            SHOW: begin
                if (!freeze) begin
                    number_nx = src_word[cur];
                    ena_nx    = 1'b1;
                    none_nx   = 1'b0;
                end else begin
                    ena_nx    = 1'b0;
                end

                // One combined condition, so next and dwell expiry together advance only once.
                advance = !src_valid[cur] || next ||
                          (mode_auto && !freeze && (dwell == DWELL_LAST));

                if (advance) begin
                    state_nx = SCAN;
                    cand_nx  = cur + 2'd1;
                    miss_nx  = 3'd0;
                    dwell_nx = '0;
                end else if (!mode_auto) begin
                    dwell_nx = '0;
                end else if (!freeze) begin
                    dwell_nx = dwell + 1'b1;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb_seg7_display_ctrl: directed bench for seg7_display_ctrl with a source-rotation reference model.
// Ports: none; drives the DUT with DWELL=4 and checks every output on each falling clock edge.
// Stimulus walks reset bring-up, auto rotation, manual step, validity loss, freeze and async reset.
module tb_seg7_display_ctrl;

    localparam int DWELL = 4;
    localparam int CNT_W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] src_data;
    logic [3:0]   src_valid;
    logic         mode_auto;
    logic         next;
    logic         freeze;
    logic [31:0]  o_number;
    logic         o_ena;
    logic [1:0]   o_src;
    logic         o_none;

    seg7_display_ctrl #(.DWELL(DWELL), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_data  (src_data),
        .src_valid (src_valid),
        .mode_auto (mode_auto),
        .next      (next),
        .freeze    (freeze),
        .o_number  (o_number),
        .o_ena     (o_ena),
        .o_src     (o_src),
        .o_none    (o_none)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = blank, 1 = searching, 2 = showing.
    // A search starts at m_base and has made m_k checks so far.
    int          m_phase, m_base, m_k, m_cur, m_age, m_c;
    logic [31:0] m_num;
    logic        m_ena, m_none, m_adv;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_base = 0; m_k = 0; m_cur = 0; m_age = 0;
            m_num = 32'd0; m_ena = 1'b0; m_none = 1'b1;
        end else begin
            case (m_phase)
                0: begin
                    m_num = 32'd0; m_ena = 1'b1; m_none = 1'b1;
                    if (src_valid != 4'd0) begin
                        m_phase = 1; m_base = m_cur; m_k = 0;
                    end
                end
                1: begin
                    m_c = (m_base + m_k) % 4;
                    if (src_valid[m_c]) begin
                        m_cur = m_c; m_age = 0; m_phase = 2;
                    end else begin
                        m_k++;
                        if (m_k == 4) m_phase = 0;
                    end
                end
                default: begin
                    if (!freeze) begin
                        m_num = src_data[32*m_cur +: 32]; m_ena = 1'b1; m_none = 1'b0;
                    end else begin
                        m_ena = 1'b0;
                    end
                    m_adv = !src_valid[m_cur] || next || (mode_auto && !freeze && m_age == DWELL - 1);
                    if (m_adv) begin
                        m_phase = 1; m_base = (m_cur + 1) % 4; m_k = 0; m_age = 0;
                    end else if (!mode_auto) begin
                        m_age = 0;
                    end else if (!freeze) begin
                        m_age++;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("mdl_number", o_number, m_num);
            check("mdl_ena", 32'(o_ena), 32'(m_ena));
            check("mdl_src", 32'(o_src), 32'(m_cur));
            check("mdl_none", 32'(o_none), 32'(m_none));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int chg_val [3];
    int chg_at  [3];
    int nchg;
    int bad;
    logic [1:0]  prev;
    logic [31:0] held;

    initial begin
        rst = 1'b1; src_valid = 4'b0001; src_data = '0; src_data[31:0] = 32'h1234_5678;
        mode_auto = 1'b0; next = 1'b0; freeze = 1'b0;
        step(3);
        check("rst_number", o_number, 32'd0);
        check("rst_ena", 32'(o_ena), 32'd0);
        check("rst_src", 32'(o_src), 32'd0);
        check("rst_none", 32'(o_none), 32'd1);

        // Bring-up: IDLE -> SCAN -> SHOW, value visible one edge after the hit.
        rst = 1'b0;
        step(1);
        check("bring_e1_none", 32'(o_none), 32'd1);
        check("bring_e1_src", 32'(o_src), 32'd0);
        step(1);
        check("bring_e2_none", 32'(o_none), 32'd1);
        check("bring_e2_number", o_number, 32'd0);
        step(1);
        check("bring_e3_none", 32'(o_none), 32'd0);
        step(1);
        check("bring_e4_number", o_number, 32'h1234_5678);
        check("bring_e4_ena", 32'(o_ena), 32'd1);

        // Auto rotation over sources 0,1,3.
        src_data[31:0] = 32'hA0A0_0000; src_data[63:32] = 32'hB1B1_1111;
        src_data[95:64] = 32'hC2C2_2222; src_data[127:96] = 32'hD3D3_3333;
        src_valid = 4'b1011; mode_auto = 1'b1;
        for (int i = 0; i < 3; i++) begin chg_val[i] = 99; chg_at[i] = 99; end
        nchg = 0; prev = o_src;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            if (o_src != prev) begin
                if (nchg < 3) begin chg_val[nchg] = int'(o_src); chg_at[nchg] = k; end
                nchg++;
                prev = o_src;
            end
        end
        check("auto_nchg", 32'(nchg), 32'd3);
        check("auto_v0", 32'(chg_val[0]), 32'd1);
        check("auto_t0", 32'(chg_at[0]), 32'd5);
        check("auto_v1", 32'(chg_val[1]), 32'd3);
        check("auto_t1", 32'(chg_at[1]), 32'd11);
        check("auto_v2", 32'(chg_val[2]), 32'd0);
        check("auto_t2", 32'(chg_at[2]), 32'd16);

        // Manual step: 0 -> (miss 1) -> 2.
        mode_auto = 1'b0; src_valid = 4'b0101;
        step(2);
        next = 1'b1;
        step(1);
        next = 1'b0;
        check("man_p0", 32'(o_src), 32'd0);
        step(1);
        check("man_p1", 32'(o_src), 32'd0);
        step(1);
        check("man_p2", 32'(o_src), 32'd2);
        bad = 0;
        repeat (100) begin
            step(1);
            if (o_src != 2'd2 || o_number != 32'hC2C2_2222) bad++;
        end
        check("man_hold", 32'(bad), 32'd0);

        // Loss of all sources, then source 2 returns.
        src_valid = 4'b0000;
        step(5);
        check("loss_scan_none", 32'(o_none), 32'd0);
        check("loss_scan_number", o_number, 32'hC2C2_2222);
        step(1);
        check("loss_idle_none", 32'(o_none), 32'd1);
        check("loss_idle_number", o_number, 32'd0);
        check("loss_idle_ena", 32'(o_ena), 32'd1);
        step(2);
        src_valid = 4'b0100;
        step(2);
        check("ret_src", 32'(o_src), 32'd2);
        check("ret_none_hold", 32'(o_none), 32'd1);
        step(1);
        check("ret_number", o_number, 32'hC2C2_2222);
        check("ret_none", 32'(o_none), 32'd0);

        // Freeze mid-dwell: value and dwell count both held.
        src_valid = 4'b0101; mode_auto = 1'b1;
        step(2);
        freeze = 1'b1; held = 32'hC2C2_2222; bad = 0;
        for (int i = 0; i < 10; i++) begin
            src_data[95:64] = 32'hF000_0000 + 32'(i);
            step(1);
            if (o_number != held || o_ena != 1'b0 || o_src != 2'd2) bad++;
        end
        check("frz_hold", 32'(bad), 32'd0);
        freeze = 1'b0; src_data[95:64] = 32'h5555_0001;
        step(1);
        check("frz_rel_number", o_number, 32'h5555_0001);
        check("frz_rel_ena", 32'(o_ena), 32'd1);
        step(2);
        check("frz_rel_e3_src", 32'(o_src), 32'd2);
        step(1);
        check("frz_rel_e4_src", 32'(o_src), 32'd0);

        // Async reset while scanning away from source 2.
        mode_auto = 1'b0;
        next = 1'b1;
        step(1);
        next = 1'b0;
        step(3);
        next = 1'b1;
        @(posedge clk);
        #1 next = 1'b0;
        check("ar_pre_src", 32'(o_src), 32'd2);
        check("ar_pre_none", 32'(o_none), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("ar_number", o_number, 32'd0);
        check("ar_ena", 32'(o_ena), 32'd0);
        check("ar_src", 32'(o_src), 32'd0);
        check("ar_none", 32'(o_none), 32'd1);
        step(2);
        rst = 1'b0;
        step(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
